// File: rtl/uart_pkg.sv
// uart_pkg: shared receive FSM states, legal prescale values and parity encodings.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    localparam int PRESCALE_8 = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;
    localparam int PRESCALE_DEFAULT = PRESCALE_8;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: captures the line around mid-bit and resolves it by 2-of-3 majority.
module uart_rx_sampler #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rxs,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      bit_val
);
    localparam logic [PRESCALE_WIDTH-1:0] ONE = 1;
    logic [PRESCALE_WIDTH-1:0] half;
    logic [2:0] smp;
    assign half = prescale >> 1;
    assign bit_val = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    always_ff @(posedge clk) begin
        if (!rst) begin
            smp <= 3'b111;
        end else begin
            if (edge_cnt == half - ONE) smp[0] <= rxs;
            if (edge_cnt == half) smp[1] <= rxs;
            if (edge_cnt == half + ONE) smp[2] <= rxs;
        end
    end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver producing one checked word per frame.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RX_IN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0]     P_DATA_REG,
    output logic                      parity_error,
    output logic                      stop_error,
    output logic                      RX_CHECK_EN
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] ONE = 1;
    rx_state_t state, nxt;
    logic sync1, rxs, par_en_q, par_typ_q, bit_val, bit_end, last_bit, legal;
    logic [PRESCALE_WIDTH-1:0] edge_cnt, p;
    logic [BW-1:0] bit_cnt;

    assign bit_end = edge_cnt == p - ONE;
    assign last_bit = bit_cnt == BW'(DATA_WIDTH - 1);
    assign legal = PRESCALE == PRESCALE_WIDTH'(PRESCALE_8) || PRESCALE == PRESCALE_WIDTH'(PRESCALE_16)
                || PRESCALE == PRESCALE_WIDTH'(PRESCALE_32);

    uart_rx_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
        .clk(clk), .rst(rst), .rxs(rxs), .edge_cnt(edge_cnt), .prescale(p), .bit_val(bit_val)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = rxs ? IDLE : START;
            START:   nxt = bit_end ? (bit_val ? IDLE : DATA) : START;
            DATA:    nxt = (bit_end && last_bit) ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  nxt = bit_end ? STOP : PARITY;
            STOP:    nxt = bit_end ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs <= 1'b1;
            edge_cnt <= '0;
            bit_cnt <= '0;
            p <= PRESCALE_WIDTH'(PRESCALE_DEFAULT);
            par_en_q <= 1'b0;
            par_typ_q <= PAR_EVEN;
            P_DATA_REG <= '0;
            parity_error <= 1'b0;
            stop_error <= 1'b0;
            RX_CHECK_EN <= 1'b0;
        end else begin
            sync1 <= RX_IN;
            rxs <= sync1;
            RX_CHECK_EN <= state == STOP && bit_end;
            if (state == IDLE) edge_cnt <= rxs ? '0 : ONE;
            else edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
            // configuration is frozen for the whole frame at start detection
            if (state == IDLE && !rxs) begin
                par_en_q <= PAR_EN;
                par_typ_q <= PAR_TYP;
                p <= legal ? PRESCALE : PRESCALE_WIDTH'(PRESCALE_DEFAULT);
            end
            if (bit_end) begin
                case (state)
                    START: if (!bit_val) begin
                        bit_cnt <= '0;
                        parity_error <= 1'b0;
                        stop_error <= 1'b0;
                    end
                    DATA: begin
                        P_DATA_REG <= {bit_val, P_DATA_REG[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                    PARITY: parity_error <= bit_val != ((par_typ_q == PAR_ODD) ? ~^P_DATA_REG : ^P_DATA_REG);
                    STOP: stop_error <= ~bit_val;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: scoreboard bench driving serial frames and checking each RX_CHECK_EN pulse.
module tb_uart_rx_frame;
    import uart_pkg::*;
    logic clk = 0, rst = 0, RX_IN = 1, PAR_EN = 0, PAR_TYP = 0;
    logic [5:0] PRESCALE = 6'd8;
    logic [7:0] P_DATA_REG;
    logic parity_error, stop_error, RX_CHECK_EN;

    typedef struct {
        logic [7:0] d;
        logic pe;
        logic se;
        int at;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int cyc = 0, n_cmp = 0, n_bad = 0;
    logic last_en = 0;
    logic [5:0] pl [3] = '{6'd8, 6'd16, 6'd32};

    uart_rx_frame dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .PRESCALE(PRESCALE), .P_DATA_REG(P_DATA_REG), .parity_error(parity_error),
        .stop_error(stop_error), .RX_CHECK_EN(RX_CHECK_EN)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (RX_CHECK_EN) begin
            check("pulse_single_cycle", 32'(last_en), 0);
            if (sb.size() == 0) check("unexpected_pulse", 32'(RX_CHECK_EN), 0);
            else begin
                e = sb.pop_front();
                check("data", 32'(P_DATA_REG), 32'(e.d));
                check("parity_error", 32'(parity_error), 32'(e.pe));
                check("stop_error", 32'(stop_error), 32'(e.se));
                check("pulse_cycle", cyc, e.at);
            end
        end
        last_en = RX_CHECK_EN;
    end

    // abort > 0 drives only that many bits and expects no pulse
    task automatic send(input logic [7:0] d, input bit pe, input bit pt, input logic [5:0] pin,
                        input bit flip, input bit stop, input int abort, input int idle);
        int p = (pin == 8 || pin == 16 || pin == 32) ? int'(pin) : 8;
        int n = 10 + int'(pe);
        logic par = (pt ? ~^d : ^d) ^ flip;
        logic [11:0] bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pe) bits[9] = par;
        bits[n-1] = stop;
        @(negedge clk);
        PAR_EN = pe;
        PAR_TYP = pt;
        PRESCALE = pin;
        if (abort == 0) sb.push_back('{d, pe & flip, ~stop, cyc + n * p + 2});
        for (int i = 0; i < ((abort > 0) ? abort : n); i++) begin
            if (i > 0) @(negedge clk);
            RX_IN = bits[i];
            repeat (p - 1) @(negedge clk);
        end
        if (idle > 0) begin
            @(negedge clk);
            RX_IN = 1'b1;
            repeat (idle - 1) @(negedge clk);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", sb.size(), 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data", 32'(P_DATA_REG), 0);
        check("reset_perr", 32'(parity_error), 0);
        check("reset_serr", 32'(stop_error), 0);
        check("reset_en", 32'(RX_CHECK_EN), 0);
        rst = 1;
        repeat (4) @(negedge clk);

        send(8'hA5, 0, 0, 6'd8, 0, 1, 0, 10);
        drain();
        send(8'h3C, 1, PAR_EVEN, 6'd16, 0, 1, 0, 10);
        send(8'h3C, 1, PAR_EVEN, 6'd16, 1, 1, 0, 10);
        drain();
        send(8'h01, 1, PAR_ODD, 6'd16, 0, 0, 0, 10);
        drain();

        @(negedge clk);
        PRESCALE = 6'd16;
        RX_IN = 0;
        repeat (3) @(negedge clk);
        RX_IN = 1;
        repeat (40) @(negedge clk);
        check("glitch_data", 32'(P_DATA_REG), 32'h01);
        check("glitch_serr_held", 32'(stop_error), 1);
        check("glitch_idle", 32'(dut.state), 32'(IDLE));

        send(8'h55, 0, 0, 6'd32, 0, 1, 0, 0);
        send(8'hAA, 0, 0, 6'd32, 0, 1, 0, 20);
        drain();

        send(8'hC3, 1, PAR_ODD, 6'd12, 0, 1, 0, 10);
        drain();

        send(8'h77, 0, 0, 6'd8, 0, 1, 6, 0);
        rst = 0;
        RX_IN = 1;
        @(negedge clk);
        check("midreset_data", 32'(P_DATA_REG), 0);
        check("midreset_perr", 32'(parity_error), 0);
        check("midreset_serr", 32'(stop_error), 0);
        check("midreset_en", 32'(RX_CHECK_EN), 0);
        rst = 1;
        repeat (5) @(negedge clk);
        send(8'h0F, 0, 0, 6'd8, 0, 1, 0, 10);
        drain();

        for (int i = 0; i < 4; i++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom), pl[$urandom_range(0, 2)],
                 1'($urandom), 1'($urandom), 0, 10);
        end
        drain();
        repeat (50) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receive framer: oversamples the serial line, detects and qualifies the start bit, deserializes DATA_WIDTH data bits LSB-first, then checks optional parity and the stop bit. It sits directly upstream of the receive check stage. Once per frame it presents the parallel word, the parity and stop error flags, and a one-cycle enable pulse to that stage.

## Interface
- DATA_WIDTH, 8, data bits per frame.
- PRESCALE_WIDTH, 6, width of PRESCALE input.
- clk  in  1  oversampling clock, runs at PRESCALE × baud.
- rst  in  1  reset, synchronous, active-low.
- RX_IN  in  1  asynchronous serial line, idle high.
- PAR_EN  in  1  1 = parity bit present after data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- PRESCALE  in  PRESCALE_WIDTH  oversampling ratio; legal values are 8, 16 and 32.
- P_DATA_REG  out  DATA_WIDTH  deserialized word.
- parity_error  out  1  parity mismatch for the last frame.
- stop_error  out  1  stop bit sampled low for the last frame.
- RX_CHECK_EN  out  1  one-cycle pulse: outputs above valid for this frame.

## Operation
- RX_IN passes through a 2-flop synchronizer; both flops reset to 1. All behaviour below refers to the synchronized line `rxs`.
- States: IDLE, START, DATA, PARITY, STOP.
- `edge_cnt` counts oversampling cycles within a bit, range 0..P-1, where P is the latched prescale. `bit_cnt` counts data bits, range 0..DATA_WIDTH-1.
- Sampling: `rxs` is captured at edge_cnt = P/2-1, P/2 and P/2+1. `bit_val` is the 2-of-3 majority of those captures. Each bit is resolved on its last edge, edge_cnt = P-1; at that edge edge_cnt wraps to 0.
- IDLE:
  - edge_cnt = 0.
  - When `rxs` = 0 (this cycle is edge 0), go to START, set edge_cnt to 1, and latch PAR_EN, PAR_TYP and PRESCALE.
  - A PRESCALE value outside {8,16,32} is latched as 8.
  - Configuration inputs are ignored for the rest of the frame.
- START, at bit end:
  - bit_val = 1 is a glitch: return to IDLE. No RX_CHECK_EN, and all outputs are unchanged.
  - Otherwise go to DATA, set bit_cnt to 0, and clear parity_error and stop_error.
- DATA, at each bit end:
  - P_DATA_REG shifts right with bit_val inserted at the MSB, so the first received bit ends up in the LSB.
  - After bit DATA_WIDTH-1, go to PARITY if PAR_EN, else to STOP.
- PARITY, at bit end: parity_error is set when bit_val ≠ expected. Expected = ^P_DATA_REG for even parity, ~^P_DATA_REG for odd parity. Then go to STOP.
- STOP, at bit end:
  - stop_error is set to ~bit_val.
  - RX_CHECK_EN is registered high for the next cycle only.
  - Go to IDLE. A start bit can be detected in the very next cycle, which supports back-to-back frames.
- When PAR_EN = 0, parity_error stays 0.
- P_DATA_REG, parity_error and stop_error hold their values until the next qualified start bit. They are stable throughout the RX_CHECK_EN cycle.
- Reset, including mid-frame:
  - State returns to IDLE.
  - edge_cnt, bit_cnt, P_DATA_REG, parity_error, stop_error and RX_CHECK_EN go to 0.
  - Synchronizer flops go to 1.
  - No pulse is generated for an aborted frame.

## Timing
- Let t be the posedge at which the synchronizer first samples RX_IN low.
- IDLE→START happens at posedge t+2.
- Frame length N = 2 + DATA_WIDTH + PAR_EN bits.
- RX_CHECK_EN is high in the cycle following posedge t + N·P + 1, for exactly 1 cycle.
- Example: DATA_WIDTH 8, parity enabled, P = 8 gives the pulse after posedge t+89.
- Start-glitch rejection completes at edge P-1 of the start bit. The FSM is in IDLE after posedge t+P+1.
- RX_CHECK_EN can never be asserted in two consecutive cycles.
- The minimum spacing between pulses is N·P cycles.

## Structure
- Shared package `uart_pkg`:
  - rx state enum (IDLE, START, DATA, PARITY, STOP).
  - Legal prescale constants (8/16/32) and the default prescale.
  - Parity type encodings (EVEN = 0, ODD = 1).
- Sub-module `uart_rx_sampler`:
  - Holds the three edge-indexed captures and the majority vote.
  - Inputs: clk, rst, rxs, edge_cnt, prescale.
  - Output: bit_val.
- The top level holds the synchronizer, FSM, counters, shift register and checks.

## Test plan
- Basic frame: P = 8, no parity, frame 0xA5 → single RX_CHECK_EN pulse 80 cycles after the start edge reaches the FSM. P_DATA_REG = 0xA5, both errors 0.
- Even parity: P = 16, even parity, 0x3C with correct parity bit 0 → P_DATA_REG = 0x3C, parity_error = 0. Same frame with parity bit 1 → parity_error = 1.
- Odd parity and stop error: odd parity, 0x01 with stop bit held low → parity_error = 0, stop_error = 1, RX_CHECK_EN still pulses.
- Start glitch: RX_IN low for 3 cycles at P = 16 → no RX_CHECK_EN, FSM back in IDLE, P_DATA_REG unchanged.
- Back-to-back: 0x55 then 0xAA with no idle gap at P = 32 → two pulses exactly N·32 cycles apart, carrying the correct data on each.
- Reset mid-frame: rst low during DATA bit 4 → all outputs 0 next cycle. A following full frame 0x0F decodes correctly.
